alu_arbiter: RTL

// - Shares the single registered ALU between two requesters (req0 = integer pipe, req1 = address/branch unit).
// - Arbitrates, issues func/op1/op2 to the ALU and holds them for the ALU latency.
// - Captures the ALU result and returns it tagged with the requester id over a valid/ready response port.
// - Sits between the decode/issue logic and the ALU; at most one operation is in flight.

---
 rtl/alu_arbiter_if.sv | 50 +++++
 rtl/alu_arbiter.sv | 96 +++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response signals of the shared-ALU arbiter bundled into one interface.
// The arbiter connects through the slave modport; issue logic, ALU and consumer use master.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FUNC_WIDTH = 4
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [FUNC_WIDTH-1:0] req0_func;
    logic [DATA_WIDTH-1:0] req0_op1;
    logic [DATA_WIDTH-1:0] req0_op2;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [FUNC_WIDTH-1:0] req1_func;
    logic [DATA_WIDTH-1:0] req1_op1;
    logic [DATA_WIDTH-1:0] req1_op2;

    logic [FUNC_WIDTH-1:0] alu_func;
    logic [DATA_WIDTH-1:0] alu_op1;
    logic [DATA_WIDTH-1:0] alu_op2;
    logic [DATA_WIDTH-1:0] alu_result;

    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_id;
    logic [DATA_WIDTH-1:0] resp_data;

    modport slave (
        input  req0_valid, req0_func, req0_op1, req0_op2,
        output req0_ready,
        input  req1_valid, req1_func, req1_op1, req1_op2,
        output req1_ready,
        output alu_func, alu_op1, alu_op2,
        input  alu_result,
        output resp_valid, resp_id, resp_data,
        input  resp_ready
    );

    modport master (
        output req0_valid, req0_func, req0_op1, req0_op2,
        input  req0_ready,
        output req1_valid, req1_func, req1_op1, req1_op2,
        input  req1_ready,
        input  alu_func, alu_op1, alu_op2,
        output alu_result,
        input  resp_valid, resp_id, resp_data,
        output resp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters, one op in flight, tagged response.
// Define ALU_ARB_FIXED_PRIO_EN for fixed req0 priority instead of round-robin.
module alu_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int FUNC_WIDTH  = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    alu_arbiter_if.slave     bus,
    output logic [1:0]       dbg_state
);
    // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high.
    // reqN_ready is a combinational grant; resp_valid holds data stable until resp_ready.
    localparam int CW = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LATENCY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          id_q;
    logic          grant1;
    logic          accept0;
    logic          accept1;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant1 = bus.req1_valid && !bus.req0_valid;
`else
    logic last_grant;
    // Under contention the requester that did not win last time goes next.
    assign grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
`endif

    assign accept0 = rst && (state == IDLE) && bus.req0_valid && !grant1;
    assign accept1 = rst && (state == IDLE) && grant1;
    assign bus.req0_ready = accept0;
    assign bus.req1_ready = accept1;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            id_q           <= 1'b0;
            bus.alu_func   <= '0;
            bus.alu_op1    <= '0;
            bus.alu_op2    <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_id    <= 1'b0;
            bus.resp_data  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant     <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept0 || accept1) begin
                        bus.alu_func <= accept1 ? bus.req1_func : bus.req0_func;
                        bus.alu_op1  <= accept1 ? bus.req1_op1  : bus.req0_op1;
                        bus.alu_op2  <= accept1 ? bus.req1_op2  : bus.req0_op2;
                        id_q         <= accept1;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant   <= accept1;
`endif
                        cnt          <= '0;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == CNT_LAST) begin
                        bus.resp_data  <= bus.alu_result;
                        bus.resp_id    <= id_q;
                        bus.resp_valid <= 1'b1;
                        // ZERO opcode makes the ALU hold its result while we wait.
                        bus.alu_func   <= '0;
                        state          <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
